// File: rtl/mem_responder.sv
// Memory-side bus target: a windowed word RAM that answers after WAIT_STATES extra cycles.
// Each request gets one mem_rdy pulse, and memdata is driven only while a read is being served.
module mem_responder #(
  parameter int          ADDR_BITS   = 10,
  parameter int          WAIT_STATES = 2,
  parameter logic [29:0] BASE        = 30'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [29:0] memaddr,
  inout  wire  [31:0] memdata,
  output logic        mem_rdy,
  output logic        mem_err
);

  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [29:0]            lat_addr;
  logic                   lat_write;
  logic [31:0]            lat_data;
  logic [31:0]            rd_data;
  logic [31:0]            ram [0:(1 << ADDR_BITS) - 1];

  logic                   sel;
  logic                   held;
  logic                   capture;
  logic                   commit;
  logic                   err_d;
  logic                   commit_write;
  logic [ADDR_BITS-1:0]   commit_idx;
  logic [31:0]            commit_data;

  assign sel  = (memaddr[29:ADDR_BITS] == BASE[29:ADDR_BITS]);
  assign held = (lat_write ? mem_we : mem_re) && (memaddr == lat_addr);

  // With zero wait states the commit happens on the capture edge, so it must use the live bus.
  assign commit_write = (state_q == ST_IDLE) ? mem_we                     : lat_write;
  assign commit_idx   = (state_q == ST_IDLE) ? memaddr[ADDR_BITS-1:0]     : lat_addr[ADDR_BITS-1:0];
  assign commit_data  = (state_q == ST_IDLE) ? memdata                    : lat_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    commit  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel && mem_re && mem_we) begin
          err_d = 1'b1;
        end else if (sel && (mem_re ^ mem_we)) begin
          capture = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (!held) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (!held) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mem_rdy <= 1'b0;
      mem_err <= 1'b0;
      rd_data <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_rdy <= commit;
      mem_err <= err_d;
      if (commit && !commit_write) begin
        rd_data <= ram[commit_idx];
      end
    end
  end

  // Request latches and RAM array carry no reset; a write only lands while out of reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      lat_addr  <= memaddr;
      lat_write <= mem_we;
      lat_data  <= memdata;
    end
    if (rst_n && commit && commit_write) begin
      ram[commit_idx] <= commit_data;
    end
  end

  assign memdata = (state_q == ST_RESP && !lat_write) ? rd_data : 32'bz;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (2 wait states at base 0, 0 wait states at base 0x400)
// checked every cycle against a request-level model, plus directed literal expectations.
module tb_mem_responder;
  localparam int AB = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        re_s   [2];
  logic        we_s   [2];
  logic        rdy_s  [2];
  logic        err_s  [2];
  logic        drv_en [2];
  logic [29:0] addr_s [2];
  logic [31:0] drv_val[2];

  tri1 [31:0] bus_a;
  tri1 [31:0] bus_b;
  assign bus_a = drv_en[0] ? drv_val[0] : 32'bz;
  assign bus_b = drv_en[1] ? drv_val[1] : 32'bz;

  mem_responder #(.ADDR_BITS(AB), .WAIT_STATES(2), .BASE(30'h0)) u_a (
    .clk(clk), .rst_n(rst_n), .mem_re(re_s[0]), .mem_we(we_s[0]), .memaddr(addr_s[0]),
    .memdata(bus_a), .mem_rdy(rdy_s[0]), .mem_err(err_s[0])
  );
  mem_responder #(.ADDR_BITS(AB), .WAIT_STATES(0), .BASE(30'h400)) u_b (
    .clk(clk), .rst_n(rst_n), .mem_re(re_s[1]), .mem_we(we_s[1]), .memaddr(addr_s[1]),
    .memdata(bus_b), .mem_rdy(rdy_s[1]), .mem_err(err_s[1])
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_ne(string nm, logic [31:0] act, logic [31:0] bad);
    n_vec++;
    if (act === bad) begin
      n_bad++;
      $display("FAIL %s: got %h, required anything but %h", nm, act, bad);
    end
  endtask

  function automatic int ws_of(int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic logic [29:0] base_of(int i);
    return (i == 0) ? 30'h0 : 30'h400;
  endfunction

  function automatic logic [31:0] bus_of(int i);
    return (i == 0) ? bus_a : bus_b;
  endfunction

  // Request-level model: a request lives from its capture edge; it answers once it has been
  // held for ws further edges, and it ends as soon as its strobe or address goes away.
  bit          m_act[2], m_wr[2], m_known[2];
  bit          e_rdy[2], e_err[2], e_drv[2];
  int          m_age[2];
  logic [29:0] m_addr[2];
  logic [31:0] m_data[2], m_rval[2];
  logic [31:0] mem[int];

  task automatic respond(int i);
    int key;
    key = i * (1 << AB) + int'(m_addr[i][AB-1:0]);
    e_rdy[i] = 1'b1;
    if (m_wr[i]) begin
      mem[key] = m_data[i];
    end else if (mem.exists(key)) begin
      m_rval[i]  = mem[key];
      m_known[i] = 1'b1;
    end else begin
      m_known[i] = 1'b0;
    end
  endtask

  task automatic model_step(int i);
    logic [29:0] b;
    bit          sel, held;
    e_rdy[i] = 1'b0;
    e_err[i] = 1'b0;
    if (!rst_n) begin
      m_act[i] = 1'b0;
      e_drv[i] = 1'b0;
      return;
    end
    b   = base_of(i);
    sel = (addr_s[i][29:AB] == b[29:AB]);
    if (!m_act[i]) begin
      if (sel && re_s[i] && we_s[i]) begin
        e_err[i] = 1'b1;
      end else if (sel && (re_s[i] ^ we_s[i])) begin
        m_act[i]  = 1'b1;
        m_wr[i]   = we_s[i];
        m_addr[i] = addr_s[i];
        m_data[i] = drv_val[i];
        m_age[i]  = 0;
        if (ws_of(i) == 0) respond(i);
      end
    end else begin
      held = (m_wr[i] ? we_s[i] : re_s[i]) && (addr_s[i] == m_addr[i]);
      if (!held) begin
        m_act[i] = 1'b0;
      end else begin
        m_age[i]++;
        if (m_age[i] == ws_of(i)) respond(i);
      end
    end
    e_drv[i] = m_act[i] && !m_wr[i] && (m_age[i] >= ws_of(i));
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
    #2;
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("rdy[%0d]", j), 32'(rdy_s[j]), 32'(e_rdy[j]));
      chk($sformatf("err[%0d]", j), 32'(err_s[j]), 32'(e_err[j]));
      if (!drv_en[j]) begin
        if (!e_drv[j]) chk($sformatf("bus released[%0d]", j), bus_of(j), 32'hFFFF_FFFF);
        else if (m_known[j]) chk($sformatf("bus data[%0d]", j), bus_of(j), m_rval[j]);
      end
    end
  end

  task automatic drive(int i, bit r, bit w, logic [29:0] a, logic [31:0] d);
    @(negedge clk);
    re_s[i] = r; we_s[i] = w; addr_s[i] = a; drv_val[i] = d; drv_en[i] = w;
  endtask

  task automatic release_bus(int i);
    @(negedge clk);
    re_s[i] = 1'b0; we_s[i] = 1'b0; drv_en[i] = 1'b0;
  endtask

  task automatic wait_rdy(int i, output int lat, output logic [31:0] q);
    lat = -1;
    q   = '0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #3;
      if (rdy_s[i]) begin
        lat = k;
        q   = bus_of(i);
        break;
      end
    end
  endtask

  task automatic access(int i, bit w, logic [29:0] a, logic [31:0] d,
                        output int lat, output logic [31:0] q);
    drive(i, !w, w, a, d);
    wait_rdy(i, lat, q);
    release_bus(i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, cnt, nq;
    logic [31:0] q;
    logic [31:0] qs[3];
    logic [5:0]  pat;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      re_s[i] = 1'b0; we_s[i] = 1'b0; addr_s[i] = '0; drv_val[i] = '0; drv_en[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #3;
    chk("reset rdy", 32'(rdy_s[0]), 32'h0);
    chk("reset err", 32'(err_s[0]), 32'h0);
    chk("reset bus", bus_a, 32'hFFFF_FFFF);

    // reset in the middle of a write's wait period drops the write
    drive(0, 0, 1, 30'h005, 32'h1234_5678);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; re_s[0] = 1'b0; we_s[0] = 1'b0; drv_en[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    access(0, 0, 30'h005, '0, lat, q);
    chk("abort read latency", 32'(lat), 32'd3);
    chk_ne("aborted write stored", q, 32'h1234_5678);

    // write then read with two wait states
    access(0, 1, 30'h003, 32'hDEAD_BEEF, lat, q);
    chk("write latency", 32'(lat), 32'd3);
    drive(0, 1, 0, 30'h003, '0);
    wait_rdy(0, lat, q);
    chk("read latency", 32'(lat), 32'd3);
    chk("read data", q, 32'hDEAD_BEEF);
    repeat (3) begin
      @(posedge clk); #3;
      chk("read data held", bus_a, 32'hDEAD_BEEF);
    end
    release_bus(0);
    @(posedge clk); #3;
    chk("read release", bus_a, 32'hFFFF_FFFF);

    // long-held write commits once; later data changes are ignored
    drive(0, 0, 1, 30'h010, 32'hA5A5_A5A5);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #3;
      if (rdy_s[0]) cnt++;
      if (k == 4) begin
        @(negedge clk);
        drv_val[0] = 32'h0;
      end
    end
    release_bus(0);
    chk("held write rdy pulses", 32'(cnt), 32'd1);
    access(0, 0, 30'h010, '0, lat, q);
    chk("held write data", q, 32'hA5A5_A5A5);

    // both strobes at once: error pulse, no access
    access(0, 1, 30'h020, 32'h1111_2222, lat, q);
    drive(0, 1, 1, 30'h020, 32'h9999_9999);
    @(posedge clk); #3;
    chk("both strobes err", 32'(err_s[0]), 32'h1);
    chk("both strobes rdy", 32'(rdy_s[0]), 32'h0);
    release_bus(0);
    @(posedge clk); #3;
    chk("err one cycle", 32'(err_s[0]), 32'h0);
    access(0, 0, 30'h020, '0, lat, q);
    chk("ram kept after err", q, 32'h1111_2222);

    // requests abandoned during the wait period
    drive(0, 0, 1, 30'h030, 32'h0000_55AA);
    @(posedge clk);
    release_bus(0);
    drive(0, 1, 0, 30'h003, '0);
    @(posedge clk);
    drive(0, 1, 0, 30'h005, '0);
    @(posedge clk);
    release_bus(0);
    repeat (3) @(posedge clk);
    access(0, 0, 30'h030, '0, lat, q);
    chk_ne("abandoned write stored", q, 32'h0000_55AA);

    // instance with base 0x400: out-of-window accesses are ignored
    drive(1, 0, 1, 30'h010, 32'h7777_7777);
    cnt = 0;
    repeat (3) begin
      @(posedge clk); #3;
      if (rdy_s[1]) cnt++;
    end
    release_bus(1);
    chk("unselected write rdy", 32'(cnt), 32'd0);
    drive(1, 1, 0, 30'h010, '0);
    repeat (2) begin
      @(posedge clk); #3;
      chk("unselected read bus", bus_b, 32'hFFFF_FFFF);
    end
    release_bus(1);

    access(1, 1, 30'h410, 32'hCAFE_F00D, lat, q);
    chk("zero-wait latency", 32'(lat), 32'd1);
    access(1, 1, 30'h400, 32'h0F0F_0F0F, lat, q);
    access(1, 1, 30'h401, 32'h0101_0101, lat, q);
    access(1, 1, 30'h402, 32'h0202_0202, lat, q);
    access(1, 0, 30'h410, '0, lat, q);
    chk("window read index 0x010", q, 32'hCAFE_F00D);

    // held read with the address stepping every two cycles
    pat = '0;
    nq  = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      re_s[1] = 1'b1; we_s[1] = 1'b0; drv_en[1] = 1'b0;
      addr_s[1] = 30'h400 + 30'(k / 2);
      @(posedge clk); #3;
      pat = {pat[4:0], rdy_s[1]};
      if (rdy_s[1] && nq < 3) begin
        qs[nq] = bus_b;
        nq++;
      end
    end
    release_bus(1);
    chk("b2b rdy pattern", 32'(pat), 32'b100101);
    chk("b2b word 0", qs[0], 32'h0F0F_0F0F);
    chk("b2b word 1", qs[1], 32'h0101_0101);
    chk("b2b word 2", qs[2], 32'h0202_0202);

    repeat (3) @(posedge clk);
    #4;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side target for the CPU bus (mem_re / mem_we / memaddr / memdata).
- Decodes a word-address window, holds a word RAM, and inserts a configurable number of wait states.
- Drives memdata for reads and commits writes once per request.
- Signals completion with mem_rdy, so the CPU and later bus masters can stall on slow memory.

Parameters:
ADDR_BITS, 10, RAM holds 2^ADDR_BITS 32-bit words; memaddr[ADDR_BITS-1:0] indexes it
WAIT_STATES, 2, extra cycles between request capture and response (0 allowed)
BASE, 30'h0, word base address; low ADDR_BITS bits must be zero

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
mem_re  input  1  read strobe, level, held by master for the whole request
mem_we  input  1  write strobe, level, held by master for the whole request
memaddr  input  30  word address
memdata  inout  32  bidirectional data; block drives only in RESP of a read, else high-Z
mem_rdy  output  1  one-cycle pulse: read data valid / write committed
mem_err  output  1  one-cycle pulse: protocol error (re and we both high while selected)

Behaviour:
- Interface (decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset state: state=IDLE, mem_rdy=0, mem_err=0, memdata=Z, wait counter=0, read-data register=0. RAM contents are not reset.
- Reset asserted mid-request aborts the request. A write not yet committed is dropped, and memdata releases immediately (asynchronous).
- Select: sel = (memaddr[29:ADDR_BITS] == BASE[29:ADDR_BITS]). If unselected, the block ignores the bus entirely: no rdy, no err, no drive.
- States: IDLE, WAIT, RESP.
- IDLE, at a rising edge with sel:
  - re xor we: latch address, direction, and (for a write) memdata. Next state is WAIT with counter=WAIT_STATES-1, or RESP when WAIT_STATES==0.
  - re and we both high: mem_err=1 for one cycle, stay IDLE, no access.
- WAIT: counter decrements each edge. At the edge where counter==0, enter RESP.
- Entering RESP (same edge):
  - Read: read-data register <= RAM[latched addr].
  - Write: RAM[latched addr] <= latched data.
  - mem_rdy=1 for exactly the first RESP cycle.
- Latency: request captured at edge E; mem_rdy high in the cycle after edge E+WAIT_STATES. That is 1 cycle for WAIT_STATES=0 and N+1 cycles for N.
- RESP, read: memdata is driven with the read-data register for as long as RESP lasts.
- RESP exit: go to IDLE at any edge where the strobe for the latched direction is low, or memaddr differs from the latched address. memdata is released in the cycle after exit. Never commit twice for one held strobe.
- Back-to-back: a master that keeps mem_re high and changes memaddr gets RESP->IDLE at one edge. The next edge captures the new request, so there is one idle bubble.
- Strobe dropped or address changed during WAIT: the request is abandoned and the block returns to IDLE.
  - A write is not committed and no rdy is issued.
  - A read returns to IDLE with no drive.
- Opposite strobe arriving during WAIT/RESP is ignored. mem_err is only evaluated in IDLE.
- memdata is high-Z at all times except RESP of a read. The block never drives during a write request.
- Address arithmetic: RAM index = latched memaddr[ADDR_BITS-1:0]. There is no wrap logic beyond truncation.

Test Plan:
- Reset, then idle bus: memdata=Z, mem_rdy=0, mem_err=0. Assert rst_n=0 mid-WAIT of a write to 0x005 with data 0x12345678, then read 0x005 -> value was not 0x12345678.
- WAIT_STATES=2: write 0xDEADBEEF to 0x003, captured at edge 0 -> mem_rdy pulses in cycle after edge 2. Then read 0x003 -> mem_rdy after 3 cycles, memdata=0xDEADBEEF held while mem_re high. Drop mem_re -> memdata Z next cycle.
- Held mem_we for 10 cycles at 0x010 with data 0xA5A5A5A5 -> exactly one mem_rdy pulse and one commit. Changing memdata mid-hold to 0x0 does not alter the stored value.
- BASE=30'h400, ADDR_BITS=10: access 0x0000_0010 -> no rdy, memdata stays Z. Access 0x410 -> normal response from RAM index 0x010.
- Both strobes high at a selected address in IDLE -> mem_err one cycle, no rdy, RAM unchanged.
- WAIT_STATES=0, mem_re held while memaddr steps 0,1,2 every 2 cycles -> rdy 1 cycle after each capture, with the correct word per address and a one-cycle bubble between responses.
